// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory access unit.
// The MMIO_EN build option uses the device register addresses below.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } mau_state_e;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    localparam int unsigned TIMEOUT_CYC_DEFAULT = 255;

endpackage

// File: rtl/mmio_decode.sv
// Combinational match and read mux for the keyboard/display device registers.
// Instantiated by mem_access_unit only when MMIO_EN is defined.
module mmio_decode
    import lc3_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              kbd_valid,
    input  logic [7:0]        kbd_data,
    input  logic              dsp_ready,
    output logic              hit,
    output logic              is_kbdr,
    output logic              is_ddr,
    output logic [DATA_W-1:0] rdata
);

    logic is_kbsr;
    logic is_dsr;

    assign is_kbsr = (addr == ADDR_W'(KBSR_ADDR));
    assign is_kbdr = (addr == ADDR_W'(KBDR_ADDR));
    assign is_dsr  = (addr == ADDR_W'(DSR_ADDR));
    assign is_ddr  = (addr == ADDR_W'(DDR_ADDR));
    assign hit     = is_kbsr | is_kbdr | is_dsr | is_ddr;

    // Status bits live in the MSB; DDR is write-only and reads as zero.
    always_comb begin
        rdata = '0;
        if (is_kbsr) begin
            rdata[DATA_W-1] = kbd_valid;
        end else if (is_kbdr) begin
            rdata[7:0] = kbd_data;
        end else if (is_dsr) begin
            rdata[DATA_W-1] = dsp_ready;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// LC-3 MAR/MDR holder and MIO_EN/R.W handshake to variable-latency memory with timeout.
// Define MMIO_EN to decode the keyboard/display registers locally instead of going to memory.
module mem_access_unit
    import lc3_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_mar,
    input  logic [ADDR_W-1:0] mar_in,
    input  logic              ld_mdr,
    input  logic [DATA_W-1:0] mdr_bus_in,
    input  logic              mio_en,
    input  logic              rw,
    output logic [ADDR_W-1:0] mar_out,
    output logic [DATA_W-1:0] mdr_out,
    output logic              r,
    output logic              busy,
    output logic              timeout_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef MMIO_EN
    ,
    input  logic [7:0]        kbd_data,
    input  logic              kbd_valid,
    output logic              kbd_ack,
    output logic [7:0]        dsp_data,
    output logic              dsp_valid,
    input  logic              dsp_ready
`endif
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    mau_state_e        state_q;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] mdr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic              r_q;
    logic              busy_q;
    logic              err_q;

`ifdef MMIO_EN
    logic              mmio_hit;
    logic              mmio_kbdr;
    logic              mmio_ddr;
    logic [DATA_W-1:0] mmio_rdata;
    logic              kbd_ack_q;
    logic [7:0]        dsp_data_q;
    logic              dsp_valid_q;

    mmio_decode #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mmio_decode (
        .addr      (mar_q),
        .kbd_valid (kbd_valid),
        .kbd_data  (kbd_data),
        .dsp_ready (dsp_ready),
        .hit       (mmio_hit),
        .is_kbdr   (mmio_kbdr),
        .is_ddr    (mmio_ddr),
        .rdata     (mmio_rdata)
    );

    assign kbd_ack   = kbd_ack_q;
    assign dsp_data  = dsp_data_q;
    assign dsp_valid = dsp_valid_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mar_q       <= '0;
            mdr_q       <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            r_q         <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef MMIO_EN
            kbd_ack_q   <= 1'b0;
            dsp_data_q  <= '0;
            dsp_valid_q <= 1'b0;
`endif
        end else begin
            r_q <= 1'b0;
`ifdef MMIO_EN
            kbd_ack_q   <= 1'b0;
            dsp_valid_q <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (ld_mdr) begin
                        mdr_q <= mdr_bus_in;
                    end
                    // A start in the same cycle as LD_MAR must use the address already held.
                    if (mio_en) begin
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
`ifdef MMIO_EN
                        if (mmio_hit) begin
                            state_q <= StDone;
                            r_q     <= 1'b1;
                            if (!rw) begin
                                mdr_q     <= mmio_rdata;
                                kbd_ack_q <= mmio_kbdr;
                            end else if (mmio_ddr) begin
                                dsp_data_q  <= mdr_q[7:0];
                                dsp_valid_q <= 1'b1;
                            end
                        end else
`endif
                        begin
                            state_q   <= StWait;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= rw;
                        end
                    end else if (ld_mar) begin
                        mar_q <= mar_in;
                    end
                end
                StWait: begin
                    if (mem_ready || cnt_q == CNT_LAST) begin
                        if (mem_ready) begin
                            if (!mem_we_q) begin
                                mdr_q <= mem_rdata;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q   <= StDone;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        r_q       <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= StIdle;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mar_out     = mar_q;
    assign mdr_out     = mdr_q;
    assign mem_addr    = mar_q;
    assign mem_wdata   = mdr_q;
    assign r           = r_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level expected outputs compared every cycle.
// Build with MMIO_EN defined to also exercise the device register path.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_mar, ld_mdr, mio_en, rw, mem_ready;
    logic [15:0] mar_in, mdr_bus_in, mem_rdata;
    logic [15:0] mar_out, mdr_out, mem_addr, mem_wdata;
    logic        r, busy, timeout_err, mem_req, mem_we;
`ifdef MMIO_EN
    logic [7:0]  kbd_data, dsp_data;
    logic        kbd_valid, kbd_ack, dsp_valid, dsp_ready;
    logic        m_kbd_ack, m_dsp_valid;
    logic [7:0]  m_dsp_data;
    int          ack_cycles, dsp_cycles;
`endif

    // Expected architectural state and per-cycle outputs.
    logic [15:0] m_mar, m_mdr;
    logic        m_req, m_we, m_r, m_busy, m_err;
    int          req_cycles, we_cycles, r_cycles;
    int          checks = 0;
    int          errors = 0;

    mem_access_unit #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_mar      (ld_mar),
        .mar_in      (mar_in),
        .ld_mdr      (ld_mdr),
        .mdr_bus_in  (mdr_bus_in),
        .mio_en      (mio_en),
        .rw          (rw),
        .mar_out     (mar_out),
        .mdr_out     (mdr_out),
        .r           (r),
        .busy        (busy),
        .timeout_err (timeout_err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
`ifdef MMIO_EN
        ,
        .kbd_data    (kbd_data),
        .kbd_valid   (kbd_valid),
        .kbd_ack     (kbd_ack),
        .dsp_data    (dsp_data),
        .dsp_valid   (dsp_valid),
        .dsp_ready   (dsp_ready)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("mar_out", mar_out, m_mar);
        check("mem_addr", mem_addr, m_mar);
        check("mdr_out", mdr_out, m_mdr);
        check("mem_wdata", mem_wdata, m_mdr);
        check("mem_req", 16'(mem_req), 16'(m_req));
        check("mem_we", 16'(mem_we), 16'(m_we));
        check("r", 16'(r), 16'(m_r));
        check("busy", 16'(busy), 16'(m_busy));
        check("timeout_err", 16'(timeout_err), 16'(m_err));
        if (mem_req) req_cycles++;
        if (mem_we) we_cycles++;
        if (r) r_cycles++;
`ifdef MMIO_EN
        check("kbd_ack", 16'(kbd_ack), 16'(m_kbd_ack));
        check("dsp_valid", 16'(dsp_valid), 16'(m_dsp_valid));
        check("dsp_data", 16'(dsp_data), 16'(m_dsp_data));
        if (kbd_ack) ack_cycles++;
        if (dsp_valid) dsp_cycles++;
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        req_cycles = 0;
        we_cycles  = 0;
        r_cycles   = 0;
`ifdef MMIO_EN
        ack_cycles = 0;
        dsp_cycles = 0;
`endif
    endtask

    task automatic model_reset();
        m_mar = '0; m_mdr = '0; m_req = 0; m_we = 0; m_r = 0; m_busy = 0; m_err = 0;
`ifdef MMIO_EN
        m_kbd_ack = 0; m_dsp_valid = 0; m_dsp_data = '0;
`endif
    endtask

    task automatic junk_inputs();
        ld_mar = 1'($urandom); mar_in = 16'($urandom);
        ld_mdr = 1'($urandom); mdr_bus_in = 16'($urandom);
        mio_en = 1'($urandom); rw = 1'($urandom);
        mem_ready = 1'($urandom); mem_rdata = 16'($urandom);
    endtask

    // One access: optional MAR/MDR load, start, wait for ready (delay cycles) or timeout, done.
    task automatic do_access(input logic [15:0] addr, input logic [15:0] wd, input logic wr,
                             input int delay, input logic [15:0] rd, input bit load);
        if (load) begin
            ld_mar = 1; mar_in = addr; ld_mdr = 1; mdr_bus_in = wd;
            mio_en = 0; mem_ready = 1'($urandom);
            tick();
            m_mar = addr; m_mdr = wd;
        end
        // A simultaneous LD_MAR must not redirect the access.
        mio_en = 1; rw = wr; ld_mar = 1'($urandom); mar_in = 16'($urandom); ld_mdr = 0;
        mem_ready = 1'($urandom); mem_rdata = 16'($urandom);
        tick();
        m_busy = 1;
`ifdef MMIO_EN
        if (m_mar == 16'hFE00 || m_mar == 16'hFE02 || m_mar == 16'hFE04 || m_mar == 16'hFE06) begin
            m_r = 1;
            if (!wr) begin
                case (m_mar)
                    16'hFE00: m_mdr = {kbd_valid, 15'b0};
                    16'hFE02: begin m_mdr = {8'b0, kbd_data}; m_kbd_ack = 1; end
                    16'hFE04: m_mdr = {dsp_ready, 15'b0};
                    default:  m_mdr = 16'h0000;
                endcase
            end else if (m_mar == 16'hFE06) begin
                m_dsp_data = m_mdr[7:0];
                m_dsp_valid = 1;
            end
        end else
`endif
        begin
            m_req = 1; m_we = wr;
            for (int k = 0; ; k++) begin
                junk_inputs();
                mem_ready = (k == delay);
                if (k == delay) mem_rdata = rd;
                tick();
                if (k == delay) begin
                    if (!wr) m_mdr = rd;
                    break;
                end
                if (k == TO - 1) begin
                    m_err = 1;
                    break;
                end
            end
            m_req = 0; m_we = 0; m_r = 1;
        end
        junk_inputs();
        tick();
        m_r = 0; m_busy = 0;
`ifdef MMIO_EN
        m_kbd_ack = 0; m_dsp_valid = 0;
`endif
        ld_mar = 0; ld_mdr = 0; mio_en = 0; mem_ready = 0;
    endtask

    initial begin
        rst_n = 0;
        ld_mar = 0; ld_mdr = 0; mio_en = 0; rw = 0; mem_ready = 0;
        mar_in = '0; mdr_bus_in = '0; mem_rdata = '0;
`ifdef MMIO_EN
        kbd_data = 8'h41; kbd_valid = 1; dsp_ready = 1;
`endif
        model_reset();
        clr_counts();
        #3;
        check("reset_mem_req", 16'(mem_req), 16'h0);
        check("reset_busy", 16'(busy), 16'h0);
        check("reset_mar", mar_out, 16'h0000);
        tick();
        rst_n = 1;
        tick();

        // Ready on the 4th wait cycle, which is also the last cycle before a timeout.
        clr_counts();
        do_access(16'h3000, 16'h0000, 0, 3, 16'hBEEF, 1);
        check("t1_req_cycles", 16'(req_cycles), 16'd4);
        check("t1_r_cycles", 16'(r_cycles), 16'd1);
        check("t1_mdr", mdr_out, 16'hBEEF);
        check("t1_err", 16'(timeout_err), 16'h0);

        clr_counts();
        do_access(16'h4000, 16'h1234, 1, 0, 16'h0000, 1);
        check("t2_req_cycles", 16'(req_cycles), 16'd1);
        check("t2_we_cycles", 16'(we_cycles), 16'd1);
        check("t2_mdr", mdr_out, 16'h1234);

        clr_counts();
        do_access(16'h6000, 16'h5555, 0, 99, 16'h0000, 1);
        check("t3_req_cycles", 16'(req_cycles), 16'd4);
        check("t3_err", 16'(timeout_err), 16'h1);
        check("t3_mdr", mdr_out, 16'h5555);
        check("t3_r_cycles", 16'(r_cycles), 16'd1);

        // Junk loads during WAIT/DONE; back-to-back start without a load.
        do_access(16'h7000, 16'h1111, 0, 2, 16'hCAFE, 1);
        check("t5_mar", mar_out, 16'h7000);
        check("t5_mdr", mdr_out, 16'hCAFE);
        check("t5_err_sticky", 16'(timeout_err), 16'h1);
        clr_counts();
        do_access(16'h0000, 16'h0000, 0, 1, 16'h0F0F, 0);
        check("b2b_mdr", mdr_out, 16'h0F0F);
        check("b2b_req_cycles", 16'(req_cycles), 16'd2);

        // Reset in the middle of WAIT.
        ld_mar = 1; mar_in = 16'h5000; ld_mdr = 1; mdr_bus_in = 16'h7777;
        tick();
        m_mar = 16'h5000; m_mdr = 16'h7777;
        ld_mar = 0; ld_mdr = 0; mio_en = 1; rw = 0;
        tick();
        m_req = 1; m_busy = 1;
        mio_en = 0;
        tick();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check("t4_mem_req", 16'(mem_req), 16'h0);
        check("t4_mar", mar_out, 16'h0000);
        check("t4_mdr", mdr_out, 16'h0000);
        check("t4_busy", 16'(busy), 16'h0);
        check("t4_err", 16'(timeout_err), 16'h0);
        tick();
        rst_n = 1;
        tick();

`ifdef MMIO_EN
        clr_counts();
        do_access(16'hFE02, 16'h0000, 0, 0, 16'h0000, 1);
        check("t6_kbdr", mdr_out, 16'h0041);
        check("t6_ack_cycles", 16'(ack_cycles), 16'd1);
        check("t6_req_cycles", 16'(req_cycles), 16'd0);
        clr_counts();
        do_access(16'hFE06, 16'h0058, 1, 0, 16'h0000, 1);
        check("t6_dsp_data", 16'(dsp_data), 16'h0058);
        check("t6_dsp_cycles", 16'(dsp_cycles), 16'd1);
        do_access(16'hFE00, 16'h0000, 0, 0, 16'h0000, 1);
        check("t6_kbsr", mdr_out, 16'h8000);
`endif

        for (int i = 0; i < 60; i++) begin
            do_access(16'($urandom) & 16'hEFFF, 16'($urandom), 1'($urandom),
                      int'($urandom_range(0, 5)), 16'($urandom), $urandom_range(0, 3) != 0);
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
